// File: rtl/systolic_arb_pkg.sv
// Shared types and helpers for the systolic job arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int MAT_W   = 128;  // 4x4 int8 operand
    localparam int RES_W   = 512;  // 4x4 int32 result
    localparam int MAX_REQ = 8;    // widest supported requester count

    // Pull operand lane k out of a packed per-requester bus. The bus is
    // zero-extended to MAX_REQ lanes by the caller, so one function serves
    // every NUM_REQ.
    function automatic logic [MAT_W-1:0] lane_sel(
        input logic [MAX_REQ*MAT_W-1:0] bus,
        input logic [2:0]               k
    );
        return bus[k*MAT_W +: MAT_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the grant.
//
// Ports:
//   req      in  NUM_REQ  request vector
//   ptr      in  IDW      highest-priority index this cycle (must be < NUM_REQ)
//   gnt      out NUM_REQ  one-hot grant (all zero when no request)
//   gnt_idx  out IDW      binary index of the granted requester
//   gnt_vld  out 1        at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_vld
);

    logic [IDW:0]   s;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        s       = '0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr + i folded back into 0..NUM_REQ-1; one extra bit is enough
            // because both terms are below NUM_REQ.
            s = {1'b0, ptr} + (IDW+1)'(i);
            if (s >= (IDW+1)'(NUM_REQ)) begin
                s = s - (IDW+1)'(NUM_REQ);
            end
            idx = s[IDW-1:0];
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/systolic_job_arbiter.sv
// Shares one 4x4 systolic MAC array between NUM_REQ requesters, one job at a time.
// Latency: accept edge T, start pulse in T+1, response the cycle after a qualified arr_done.
// Backpressure: RESP holds result until resp_ready; no request is accepted while busy.
//
// Optional feature macro: SYSTOLIC_ARB_TIMEOUT_EN (WAIT-state timeout, flags resp_err).
//
// Ports:
//   clk, reset                    clock (rising edge), async active-low reset
//   req_valid/req_ready           per-requester request, one-hot accept pulse
//   req_A/req_B                   packed operands, requester k at [k*128 +: 128]
//   arr_valid_in                  one-cycle start pulse to the array
//   arr_matrix_A/arr_matrix_B     latched operands, stable for the whole job
//   arr_y/arr_done                array result bus and (sticky) done flag
//   resp_valid/resp_ready         result handshake
//   resp_id/resp_y/resp_err       owner, captured result, timeout flag
//   busy                          high outside IDLE
//   jobs_done                     completed-response counter, wraps at 16 bits
module systolic_job_arbiter
    import systolic_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IDW            = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*MAT_W-1:0] req_A,
    input  logic [NUM_REQ*MAT_W-1:0] req_B,
    output logic                     arr_valid_in,
    output logic [MAT_W-1:0]         arr_matrix_A,
    output logic [MAT_W-1:0]         arr_matrix_B,
    input  logic [RES_W-1:0]         arr_y,
    input  logic                     arr_done,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [IDW-1:0]           resp_id,
    output logic [RES_W-1:0]         resp_y,
    output logic                     resp_err,
    output logic                     busy,
    output logic [15:0]              jobs_done
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("systolic_job_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t             state, state_nxt;
    logic [IDW-1:0]         ptr;
    logic                   first_wait;
    logic                   done_ok;
    logic                   timeout_hit;

    logic [NUM_REQ-1:0]     gnt;
    logic [IDW-1:0]         gnt_idx;
    logic                   gnt_vld;
    logic                   accept;

    logic [MAX_REQ*MAT_W-1:0] a_ext, b_ext;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[NUM_REQ*MAT_W-1:0] = req_A;
        b_ext[NUM_REQ*MAT_W-1:0] = req_B;
    end

    assign accept = (state == IDLE) && gnt_vld;

    // The array's done flag is still set from the previous job during the
    // first WAIT cycle, so only later cycles may count as completion.
    assign done_ok = (state == WAIT) && !first_wait && arr_done;

`ifdef SYSTOLIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    // Counts WAIT cycles from 0; WAIT lasts at most TIMEOUT_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == ISSUE) begin
            to_cnt <= '0;
        end else if (state == WAIT) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == WAIT) && !done_ok &&
                         (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign resp_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done_ok || timeout_hit) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready is gated by reset too, so it drops to zero asynchronously
    // even though the grant itself is combinational from req_valid.
    assign req_ready    = (accept && reset) ? gnt : '0;
    assign arr_valid_in = (state == ISSUE);
    assign resp_valid   = (state == RESP);
    assign busy         = (state != IDLE);

    // Datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr          <= '0;
            first_wait   <= 1'b0;
            arr_matrix_A <= '0;
            arr_matrix_B <= '0;
            resp_id      <= '0;
            resp_y       <= '0;
            jobs_done    <= '0;
        end else begin
            first_wait <= (state == ISSUE);

            if (accept) begin
                arr_matrix_A <= lane_sel(a_ext, 3'(gnt_idx));
                arr_matrix_B <= lane_sel(b_ext, 3'(gnt_idx));
                resp_id      <= gnt_idx;
                ptr          <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end

            if (done_ok) begin
                resp_y <= arr_y;
            end else if (timeout_hit) begin
                resp_y <= '0;
            end

            if ((state == RESP) && resp_ready) begin
                jobs_done <= jobs_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_systolic_job_arbiter.sv
module tb_systolic_job_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*128-1:0] req_A, req_B;
    logic             arr_valid_in;
    logic [127:0]     arr_matrix_A, arr_matrix_B;
    logic [511:0]     arr_y;
    logic             arr_done;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic [511:0]     resp_y;
    logic             resp_err;
    logic             busy;
    logic [15:0]      jobs_done;

    systolic_job_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_A        (req_A),
        .req_B        (req_B),
        .arr_valid_in (arr_valid_in),
        .arr_matrix_A (arr_matrix_A),
        .arr_matrix_B (arr_matrix_B),
        .arr_y        (arr_y),
        .arr_done     (arr_done),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_y       (resp_y),
        .resp_err     (resp_err),
        .busy         (busy),
        .jobs_done    (jobs_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // model state
    bit           model_on = 1'b1;
    bit           outstanding, done_seen;
    int           acc, due, mptr, exp_jobs, cur_id, cyc, pulses;
    logic [127:0] cur_a, cur_b;
    logic [511:0] cur_y, dut_last_y;
    int           dut_last_id;
    int           glog[$];
    int           seq[N];
    logic [N-1:0] rearm, granted;
    // array model state
    int           lat, alat, acnt;
    bit           pend;
    logic [127:0] la, lb;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] matmul(input logic [127:0] a, input logic [127:0] b);
        logic [511:0] r;
        int           s;
        logic [7:0]   ea, eb;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    ea = 8'(a >> (120 - 8*(i*4+k)));
                    eb = 8'(b >> (120 - 8*(k*4+j)));
                    s += int'($signed(ea)) * int'($signed(eb));
                end
                r = r | ({480'b0, 32'(s)} << (480 - 32*(i*4+j)));
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] gen_op(input int k, input int s, input int salt);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            r = (r << 8) | {120'b0, 8'(k*37 + s*11 + b*(5+salt) - 60 + salt*13)};
        end
        return r;
    endfunction

    function automatic logic [N*128-1:0] put_lane(input logic [N*128-1:0] bus, input int k,
                                                  input logic [127:0] v);
        logic [N*128-1:0] m, x;
        m = {{((N-1)*128){1'b0}}, {128{1'b1}}};
        x = {{((N-1)*128){1'b0}}, v};
        return (bus & ~(m << (k*128))) | (x << (k*128));
    endfunction

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (((v >> ((p+i) % N)) & 1) != 0) return (p+i) % N;
        end
        return -1;
    endfunction

    // Per-cycle comparison against the behavioural model, sampled at negedge.
    task automatic model_compare();
        logic [N-1:0] er;
        bit           ev;
        int           gk;
        if (!reset) begin
            outstanding = 1'b0; done_seen = 1'b0;
            mptr = 0; exp_jobs = 0; granted = '0;
            return;
        end
        granted = granted | req_ready;
        if (resp_valid && resp_ready) begin
            dut_last_y  = resp_y;
            dut_last_id = int'(resp_id);
        end
        if (!model_on) return;

        er = '0;
        if (!outstanding && req_valid != '0) er = N'(1) << rr_pick(mptr, req_valid);
        ev = outstanding && done_seen && (cyc >= due);

        chk("jobs_done", 512'(jobs_done), 512'(16'(exp_jobs)));
        chk("req_ready_onehot", 512'($countones(req_ready) <= 1), 512'(1));
        chk("req_ready", 512'(req_ready), 512'(er));
        chk("arr_valid_in", 512'(arr_valid_in), 512'(outstanding && cyc == acc + 1));
        chk("busy", 512'(busy), 512'(outstanding));
        chk("resp_valid", 512'(resp_valid), 512'(ev));
        if (outstanding && cyc > acc) begin
            chk("arr_matrix_A", 512'(arr_matrix_A), 512'(cur_a));
            chk("arr_matrix_B", 512'(arr_matrix_B), 512'(cur_b));
        end
        if (ev) begin
            chk("resp_id", 512'(resp_id), 512'(cur_id));
            chk("resp_y", resp_y, cur_y);
            chk("resp_err", 512'(resp_err), 512'(0));
        end
        if (arr_valid_in) pulses++;

        if (outstanding && !done_seen && cyc >= acc + 3 && arr_done) begin
            done_seen = 1'b1;
            due = cyc + 1;
        end
        if (ev && resp_ready) begin
            outstanding = 1'b0;
            exp_jobs = (exp_jobs + 1) % 65536;
        end
        if (req_ready != '0 && !outstanding) begin
            gk = 0;
            for (int k = 0; k < N; k++) if (((req_ready >> k) & 1) != 0) gk = k;
            outstanding = 1'b1; done_seen = 1'b0;
            acc = cyc; cur_id = gk;
            cur_a = 128'(req_A >> (gk*128));
            cur_b = 128'(req_B >> (gk*128));
            cur_y = matmul(cur_a, cur_b);
            mptr = (gk + 1) % N;
            glog.push_back(gk);
        end
    endtask

    // Array and requester behaviour, applied just after each rising edge.
    task automatic drive();
        if (!reset) begin
            pend = 1'b0; arr_done = 1'b0;
        end else if (arr_valid_in) begin
            pend = 1'b1; acnt = 0; alat = lat;
            la = arr_matrix_A; lb = arr_matrix_B;
        end else if (pend) begin
            acnt++;
            if (acnt >= alat) begin
                arr_done = 1'b1; arr_y = matmul(la, lb); pend = 1'b0;
            end else if (acnt == 2) begin
                arr_done = 1'b0;   // done stays sticky through ISSUE and first WAIT cycle
            end
        end
        for (int k = 0; k < N; k++) begin
            if (((granted >> k) & 1) != 0) begin
                seq[k]++;
                if (((rearm >> k) & 1) != 0) begin
                    req_A = put_lane(req_A, k, gen_op(k, seq[k], 0));
                    req_B = put_lane(req_B, k, gen_op(k, seq[k], 1));
                end else begin
                    req_valid = req_valid & ~(N'(1) << k);
                end
            end
        end
        granted = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic wait_jobs(input int n, input int budget);
        for (int t = 0; t < budget && jobs_done != 16'(n); t++) tick();
        chk("wait_jobs", 512'(jobs_done), 512'(16'(n)));
    endtask

    task automatic load(input int k);
        req_A = put_lane(req_A, k, gen_op(k, seq[k], 0));
        req_B = put_lane(req_B, k, gen_op(k, seq[k], 1));
    endtask

    localparam logic [127:0] IDENT = 128'h01000000_00010000_00000100_00000001;
    localparam logic [127:0] BMAT  = 128'h01020304_05060708_090a0b0c_0d0e0f10;
    localparam logic [511:0] BEXT  = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8,
                                      32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16};

    initial begin
        int exp_order[6];
        exp_order = '{0, 1, 3, 0, 1, 3};
        req_valid = 4'b1111; req_A = '0; req_B = '0; resp_ready = 1'b1;
        arr_done = 1'b0; arr_y = '0; rearm = '0; granted = '0; lat = 5;
        cyc = 0; pulses = 0;
        for (int k = 0; k < N; k++) seq[k] = 0;

        // reset state
        repeat (2) tick();
        chk("reset_req_ready", 512'(req_ready), 512'(0));
        chk("reset_busy", 512'(busy), 512'(0));
        chk("reset_jobs_done", 512'(jobs_done), 512'(0));
        chk("reset_resp_y", resp_y, 512'(0));
        chk("reset_arr_A", 512'(arr_matrix_A), 512'(0));
        req_valid = '0;
        reset = 1'b1;

        // pin the model against a hand-computed product
        chk("model_identity", matmul(IDENT, BMAT), BEXT);

        // identity job from requester 0
        req_A = put_lane(req_A, 0, IDENT);
        req_B = put_lane(req_B, 0, BMAT);
        req_valid = 4'b0001;
        wait_jobs(1, 40);
        chk("identity_resp_y", dut_last_y, BEXT);
        chk("identity_resp_id", 512'(dut_last_id), 512'(0));
        chk("identity_pulses", 512'(pulses), 512'(1));

        // backpressure: requester 2, ptr is 1 now
        load(2);
        req_valid = 4'b0100;
        resp_ready = 1'b0;
        for (int t = 0; t < 40 && !resp_valid; t++) tick();
        chk("bp_resp_valid_seen", 512'(resp_valid), 512'(1));
        load(1);
        req_valid[1] = 1'b1;
        repeat (20) tick();
        chk("bp_jobs_held", 512'(jobs_done), 512'(1));
        chk("bp_resp_id", 512'(resp_id), 512'(2));
        lat = 1000;
        resp_ready = 1'b1;
        wait_jobs(2, 10);

        // requester 1 now sits in WAIT forever; reset in the middle of it
        repeat (8) tick();
        chk("wait_busy", 512'(busy), 512'(1));
        chk("wait_grant_id", 512'(glog[glog.size()-1]), 512'(1));
        load(0); load(1); load(3);
        req_valid = 4'b1011;
        rearm = 4'b1011;
        reset = 1'b0;
        #1;
        chk("async_req_ready", 512'(req_ready), 512'(0));
        chk("async_busy", 512'(busy), 512'(0));
        chk("async_resp_valid", 512'(resp_valid), 512'(0));
        chk("async_arr_valid_in", 512'(arr_valid_in), 512'(0));
        chk("async_jobs_done", 512'(jobs_done), 512'(0));
        chk("async_resp_y", resp_y, 512'(0));
        chk("async_resp_id", 512'(resp_id), 512'(0));
        chk("async_arr_B", 512'(arr_matrix_B), 512'(0));
        repeat (2) tick();
        glog.delete();
        reset = 1'b1;

        // contention with ptr back at 0
        for (int t = 0; t < 200 && glog.size() < 3; t++) begin
            lat = (glog.size() % 2 == 1) ? 5 : 2;
            tick();
        end
        rearm = '0;
        for (int t = 0; t < 300 && !(glog.size() >= 6 && !busy); t++) tick();
        chk("cont_grants", 512'(glog.size()), 512'(6));
        for (int i = 0; i < 6 && i < glog.size(); i++) begin
            chk($sformatf("cont_order_%0d", i), 512'(glog[i]), 512'(exp_order[i]));
        end
        chk("cont_jobs_done", 512'(jobs_done), 512'(6));

`ifdef SYSTOLIC_ARB_TIMEOUT_EN
        model_on = 1'b0;
        lat = 100000;
        load(0);
        req_valid = 4'b0001;
        resp_ready = 1'b0;
        for (int t = 0; t < 40 && !resp_valid; t++) tick();
        chk("to_resp_valid", 512'(resp_valid), 512'(1));
        chk("to_resp_err", 512'(resp_err), 512'(1));
        chk("to_resp_y", resp_y, 512'(0));
        resp_ready = 1'b1;
        tick();
        lat = 3;
        load(0);
        req_valid = 4'b0001;
        for (int t = 0; t < 10 && !busy; t++) tick();
        chk("to_err_cleared", 512'(resp_err), 512'(0));
        for (int t = 0; t < 40 && busy; t++) tick();
        chk("to_jobs_done", 512'(jobs_done), 512'(8));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/systolic_job_arbiter.md
Name: systolic_job_arbiter

Overview:
- Shares one 4x4 systolic MAC array between NUM_REQ independent requesters.
- Accepts one matrix-multiply job at a time using round-robin arbitration and latches its operands.
- Issues the job to the array with a single-cycle start pulse, waits for completion, then returns the 512-bit result tagged with the requester ID.
- Sits directly above the systolic array and drives its valid_in, matrix_A and matrix_B inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, $clog2(NUM_REQ), width of the requester ID.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only with SYSTOLIC_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Integration inverts it for the array, whose reset is active-high.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_A  in  NUM_REQ*128  packed A operands. Requester k occupies [k*128+:128]; row-major int8 with a[0][0] in the MSB.
- req_B  in  NUM_REQ*128  packed B operands, same layout as req_A.
- arr_valid_in  out  1  start pulse to the array.
- arr_matrix_A  out  128  operand A to the array.
- arr_matrix_B  out  128  operand B to the array.
- arr_y  in  512  array result bus (16 x int32, C[0][0] in the MSB).
- arr_done  in  1  array done_matrix_mult.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  IDW  requester that owns the result.
- resp_y  out  512  captured result.
- resp_err  out  1  result invalid because of a timeout.
- busy  out  1  high in every state except IDLE.
- jobs_done  out  16  count of completed responses; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; round-robin pointer goes to 0.
  - All outputs are 0: req_ready, arr_valid_in, resp_valid, resp_err, busy, jobs_done, resp_y, resp_id, arr_matrix_A/B.
  - Reset asserted mid-job abandons the job with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant the first k with req_valid[k]=1, searching from ptr upward with wrap-around.
  - Drive req_ready[k]=1 combinationally in that same cycle. Never more than one req_ready bit is high.
  - On that edge: latch req_A[k] and req_B[k] into arr_matrix_A/B, latch k into resp_id, set ptr=(k+1) mod NUM_REQ, go to ISSUE.
  - With no valid request: stay in IDLE; ptr is unchanged.
- ISSUE: arr_valid_in=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - arr_matrix_A/B stay stable throughout.
  - arr_done is ignored in the first WAIT cycle, because the array's done flag is sticky from the previous job.
  - From the second WAIT cycle on, the first cycle with arr_done=1 captures arr_y into resp_y and moves to RESP.
- RESP:
  - resp_valid=1; resp_y, resp_id and resp_err are held stable until resp_ready=1.
  - On the edge where resp_valid & resp_ready: jobs_done increments, go to IDLE.
  - resp_ready may already be high when RESP is entered; the handshake then completes in one cycle.
- Latency: accept at edge T -> arr_valid_in during cycle T+1 -> resp_valid in the cycle after the edge that samples arr_done.
- Requesters must keep req_valid and their operands stable until req_ready is seen. A requester that drops req_valid before grant is simply skipped.
- With simultaneous requests, every requester is served within NUM_REQ jobs (no starvation).
- No new job is accepted while busy=1. req_ready is 0 in ISSUE, WAIT and RESP.

Optional Feature:
- Macro: SYSTOLIC_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT; it is cleared on entering WAIT.
  - When the counter reaches TIMEOUT_CYCLES without a qualified arr_done: resp_y=0, resp_err=1, go to RESP.
  - jobs_done still increments on that handshake.
  - resp_err clears when the next job is accepted.
- Not defined: no counter logic is built; resp_err is tied to 0; WAIT waits indefinitely.

Decomposition:
- Package systolic_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP};
  - MAT_W=128 and RES_W=512 constants;
  - a function to extract lane k from a packed operand bus.
- Sub-module rr_arbiter (NUM_REQ parameterised): request vector + pointer -> one-hot grant and grant index. It is purely combinational; the pointer register stays in the top level.

Test Plan:
- Identity job: requester 0 sends A=identity (diagonal 0x01) and B with rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}.
  -> One arr_valid_in pulse; resp_id=0; resp_y equals B sign-extended to int32; jobs_done=1.
- Contention: req_valid=4'b1011 held with ptr=0.
  -> Grants in order 0, 1, 3; then 0 again if still valid. req_ready is never multi-hot.
- Backpressure: resp_ready held low for 20 cycles after resp_valid.
  -> resp_y and resp_id are stable; no new req_ready is issued; exactly one jobs_done increment when resp_ready rises.
- Sticky done: arr_done is held 1 across ISSUE and into the first WAIT cycle.
  -> That first-WAIT-cycle arr_done is not taken as completion; RESP is entered only on arr_done in a later WAIT cycle.
- Reset mid-WAIT: reset driven low for 2 cycles.
  -> All outputs are 0 immediately (asynchronously); after release the FSM is in IDLE and ptr=0.
- With SYSTOLIC_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8: arr_done is held low.
  -> resp_valid rises with resp_err=1 and resp_y=0; the next accepted job clears resp_err.
